// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the decade up and down counters.
// Contents:
//   BCD_W        - width of one BCD digit
//   BCD_MAX      - largest legal digit value (9)
//   BCD_ZERO     - zero digit value
//   bcd_sanitise - clamps a 4-bit value to a legal BCD digit (10..15 -> 9)
package bcd_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic [BCD_W-1:0] bcd_sanitise(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_counter_if.sv
// Bus bundle for bcd_down_counter.
// Signals:
//   load     - synchronous parallel load strobe (master -> slave)
//   load_val - 4*DIGITS load value, digit i in bits [4i+3:4i] (master -> slave)
//   en       - count enable (master -> slave)
//   count    - registered BCD count (slave -> master)
//   zero     - count is all zeros (slave -> master)
//   bout     - borrow-out for cascading into a higher counter's en (slave -> master)
//   done     - one-cycle pulse after a terminal (zero) decrement (slave -> master)
interface bcd_down_counter_if #(
    parameter int DIGITS = 2
);

    logic                              load;
    logic [bcd_pkg::BCD_W*DIGITS-1:0]  load_val;
    logic                              en;
    logic [bcd_pkg::BCD_W*DIGITS-1:0]  count;
    logic                              zero;
    logic                              bout;
    logic                              done;

    modport master (
        output load, load_val, en,
        input  count, zero, bout, done
    );

    modport slave (
        input  load, load_val, en,
        output count, zero, bout, done
    );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down counter.
// Ports:
//   clk      - clock
//   clr      - asynchronous active-high clear
//   load     - load ld_digit (sanitised to 0..9)
//   ld_digit - digit value to load
//   dec      - decrement this digit (0 or invalid -> 9)
//   q        - registered digit value
//   is_zero  - q equals 0
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [BCD_W-1:0] ld_digit,
    input  logic             dec,
    output logic [BCD_W-1:0] q,
    output logic             is_zero
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= BCD_ZERO;
        end else if (load) begin
            q <= bcd_sanitise(ld_digit);
        end else if (dec) begin
            // Zero borrows to 9; an invalid digit (only via X/upset) also recovers to 9.
            q <= (q == BCD_ZERO || q > BCD_MAX) ? BCD_MAX : q - 4'd1;
        end
    end

    assign is_zero = (q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down counter with parallel load, enable, borrow-out,
// zero flag and a one-cycle done pulse on each terminal (at-zero) decrement.
// Parameters:
//   DIGITS - number of BCD digits (1..8)
//   WRAP   - 1: zero wraps to all nines; 0: zero holds
// Ports:
//   clk - clock
//   clr - asynchronous active-high clear (count -> 0, done -> 0)
//   bus - slave side of bcd_down_counter_if (load/load_val/en in,
//         count/zero/bout/done out)
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                 clk,
    input  logic                 clr,
    bcd_down_counter_if.slave    bus
);

    logic [DIGITS-1:0]       is_zero;
    logic [DIGITS-1:0]       dec;
    logic [BCD_W*DIGITS-1:0] count_q;
    logic                    all_zero;
    logic                    hold_at_zero;
    logic                    done_q;

    assign all_zero     = &is_zero;
    // One-shot mode freezes every digit once the whole count reaches zero.
    assign hold_at_zero = (WRAP == 1'b0) && all_zero;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        // Mask of the digits below digit i; empty for digit 0, so it always borrows.
        localparam logic [DIGITS-1:0] LOWER = DIGITS'((64'd1 << i) - 64'd1);

        assign dec[i] = bus.en & ~hold_at_zero & (&(is_zero | ~LOWER));

        bcd_down_digit u_digit (
            .clk      (clk),
            .clr      (clr),
            .load     (bus.load),
            .ld_digit (bus.load_val[BCD_W*i +: BCD_W]),
            .dec      (dec[i]),
            .q        (count_q[BCD_W*i +: BCD_W]),
            .is_zero  (is_zero[i])
        );
    end

    // done flags an enabled edge taken at zero, in either WRAP mode; load wins.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            done_q <= 1'b0;
        end else begin
            done_q <= bus.en & ~bus.load & all_zero;
        end
    end

    assign bus.count = count_q;
    assign bus.zero  = all_zero;
    // Gated by clr so a cascaded counter sees no borrow while the chain is cleared.
    assign bus.bout  = bus.en & all_zero & ~bus.load & ~clr;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: table-driven countdown/load
// vectors on a 2-digit wrapping counter, plus hand sequences for async clear,
// one-shot (WRAP=0) terminal behaviour and a two-stage cascade.
module tb_bcd_down_counter;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    bcd_down_counter_if #(.DIGITS(2)) d2_if ();
    bcd_down_counter_if #(.DIGITS(2)) os_if ();
    bcd_down_counter_if #(.DIGITS(1)) lo_if ();
    bcd_down_counter_if #(.DIGITS(1)) hi_if ();
    bcd_down_counter_if #(.DIGITS(2)) rf_if ();

    bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) u_d2 (.clk(clk), .clr(clr), .bus(d2_if));
    bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) u_os (.clk(clk), .clr(clr), .bus(os_if));
    bcd_down_counter #(.DIGITS(1), .WRAP(1'b1)) u_lo (.clk(clk), .clr(clr), .bus(lo_if));
    bcd_down_counter #(.DIGITS(1), .WRAP(1'b1)) u_hi (.clk(clk), .clr(clr), .bus(hi_if));
    bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) u_rf (.clk(clk), .clr(clr), .bus(rf_if));

    // Cascade: low stage borrow-out enables the high stage.
    assign hi_if.en = lo_if.bout;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       load;
        logic [7:0] load_val;
        logic       en;
        logic [7:0] exp_count;
        logic       exp_done;
        logic       exp_bout;   // bout with these inputs applied, before the edge
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ld, input logic [7:0] lv, input logic e,
                       input logic [7:0] ec, input logic ed, input logic eb);
        vec_t v;
        v.load = ld; v.load_val = lv; v.en = e;
        v.exp_count = ec; v.exp_done = ed; v.exp_bout = eb;
        vecs.push_back(v);
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cnt;
        logic [7:0] casc;
        int         model;
        int         prev;

        d2_if.load = 1'b0; d2_if.load_val = '0; d2_if.en = 1'b1;
        os_if.load = 1'b0; os_if.load_val = '0; os_if.en = 1'b0;
        lo_if.load = 1'b0; lo_if.load_val = '0; lo_if.en = 1'b0;
        hi_if.load = 1'b0; hi_if.load_val = '0;
        rf_if.load = 1'b0; rf_if.load_val = '0; rf_if.en = 1'b0;

        // ---- reset state (en held high to show bout stays low under clr)
        #12;
        check("reset_count", 32'(d2_if.count), 32'h00);
        check("reset_done",  32'(d2_if.done),  32'h0);
        check("reset_zero",  32'(d2_if.zero),  32'h1);
        check("reset_bout",  32'(d2_if.bout),  32'h0);
        d2_if.en = 1'b0;
        clr = 1'b0;

        // ---- async clear mid-count from 57
        d2_if.load = 1'b1; d2_if.load_val = 8'h57;
        step();
        check("load_57", 32'(d2_if.count), 32'h57);
        d2_if.load = 1'b0; d2_if.en = 1'b1;
        #3 clr = 1'b1;
        #1;
        check("clr_mid_count", 32'(d2_if.count), 32'h00);
        check("clr_mid_zero",  32'(d2_if.zero),  32'h1);
        check("clr_mid_done",  32'(d2_if.done),  32'h0);
        check("clr_mid_bout",  32'(d2_if.bout),  32'h0);
        d2_if.en = 1'b0;
        #2 clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_after_clr_count", 32'(d2_if.count), 32'h00);
            check("hold_after_clr_done",  32'(d2_if.done),  32'h0);
        end

        // ---- table: load 12 and count through the wrap, then loads/priority
        add(1'b1, 8'h12, 1'b1, 8'h12, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h09, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h08, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h07, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h06, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 8'h98, 1'b0, 1'b0);
        add(1'b1, 8'hA3, 1'b0, 8'h93, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 1'b1, 8'h99, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h99, 1'b0, 1'b0);
        add(1'b1, 8'h40, 1'b0, 8'h40, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h39, 1'b0, 1'b0);
        add(1'b1, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h09, 1'b0, 1'b0);
        add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 8'h45, 1'b1, 8'h45, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h45, 1'b0, 1'b0);

        foreach (vecs[k]) begin
            d2_if.load     = vecs[k].load;
            d2_if.load_val = vecs[k].load_val;
            d2_if.en       = vecs[k].en;
            #1;
            check($sformatf("vec%0d_bout", k), 32'(d2_if.bout), 32'(vecs[k].exp_bout));
            step();
            check($sformatf("vec%0d_count", k), 32'(d2_if.count), 32'(vecs[k].exp_count));
            check($sformatf("vec%0d_done", k),  32'(d2_if.done),  32'(vecs[k].exp_done));
            check($sformatf("vec%0d_zero", k),  32'(d2_if.zero),  32'(vecs[k].exp_count == 8'h00));
        end
        d2_if.load = 1'b0; d2_if.en = 1'b0;

        // ---- one-shot: load 03, six enabled edges
        os_if.load = 1'b1; os_if.load_val = 8'h03;
        step();
        check("os_load", 32'(os_if.count), 32'h03);
        os_if.load = 1'b0; os_if.en = 1'b1;
        cnt = 8'h03;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("os_bout", 32'(os_if.bout), 32'(cnt == 8'h00));
            prev = (cnt == 8'h00) ? 1 : 0;
            cnt  = (cnt == 8'h00) ? 8'h00 : cnt - 8'h01;
            step();
            check("os_count", 32'(os_if.count), 32'(cnt));
            check("os_done",  32'(os_if.done),  32'(prev));
        end
        os_if.en = 1'b0;
        #1;
        check("os_bout_en0", 32'(os_if.bout), 32'h0);
        step();
        check("os_hold_count", 32'(os_if.count), 32'h00);
        check("os_hold_done",  32'(os_if.done),  32'h0);
        os_if.en = 1'b1;
        step();
        check("os_repulse_done", 32'(os_if.done), 32'h1);
        #3 clr = 1'b1;
        #1;
        check("os_clr_done", 32'(os_if.done), 32'h0);
        os_if.en = 1'b0;
        #2 clr = 1'b0;

        // ---- cascade of two 1-digit stages against a 2-digit reference
        lo_if.load = 1'b1; lo_if.load_val = 4'h0;
        hi_if.load = 1'b1; hi_if.load_val = 4'h2;
        rf_if.load = 1'b1; rf_if.load_val = 8'h20;
        lo_if.en = 1'b1; rf_if.en = 1'b1;
        step();
        casc = {hi_if.count, lo_if.count};
        check("casc_load", 32'(casc), 32'h20);
        check("casc_ref_load", 32'(rf_if.count), 32'h20);
        lo_if.load = 1'b0; hi_if.load = 1'b0; rf_if.load = 1'b0;
        model = 20;
        for (int i = 0; i < 22; i++) begin
            prev  = (model == 0) ? 1 : 0;
            model = (model == 0) ? 99 : model - 1;
            step();
            casc = {hi_if.count, lo_if.count};
            check("casc_count", 32'(casc), 32'(to_bcd(model)));
            check("casc_ref",   32'(rf_if.count), 32'(to_bcd(model)));
            check("casc_ref_done", 32'(rf_if.done), 32'(prev));
        end
        lo_if.en = 1'b0; rf_if.en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

Synchronous multi-digit decade (BCD) down counter with parallel load. It is the counting-down counterpart of the team's BCD up counter, used for countdown timers and as the decrementing end of paired up/down BCD counter chains. It supports enable, a cascadable borrow-out, a zero flag, and a one-cycle `done` pulse when the count passes through zero.

## Interface
- `DIGITS`, default 2: number of BCD digits. Legal range is 1–8.
- `WRAP`, default 1: terminal behaviour.
  - 1: zero wraps to all-nines.
  - 0: zero holds (one-shot countdown).
- `clk`  in  1: clock. All state changes on the rising edge.
- `clr`  in  1: reset, asynchronous, active-high.
- `load`  in  1: synchronous parallel load strobe.
- `load_val`  in  4*DIGITS: load value. Digit *i* occupies bits [4i+3:4i]; digit 0 is least significant.
- `en`  in  1: count enable. Decrements once per enabled edge.
- `count`  out  4*DIGITS: current BCD value, registered.
- `zero`  out  1: high when `count` is all zeros. Combinational from `count`.
- `bout`  out  1: borrow-out, equal to `en & zero & ~load`. Combinational, for cascading into a higher counter's `en`.
- `done`  out  1: registered, one-cycle pulse; see Operation.

## Operation
Priority order is `clr` > `load` > `en` > hold.

- **Reset.** `clr` high clears `count` to 0 and `done` to 0 immediately, independent of `clk`. While `clr` is high, `zero`=1 and `bout`=0.
- **Load.** On an edge with `load`=1, `count` <= `load_val`, sanitised per digit: any digit value 10–15 is loaded as 9.
  - `en` is ignored on that edge.
  - `done` is 0 on the following cycle.
- **Decrement.** On an edge with `en`=1 and `load`=0:
  - Digit 0 decrements every enabled edge.
  - Digit *i* (i>0) decrements only when `en` is high and all lower digits are 0 (borrow ripple).
  - A digit at 0 that decrements becomes 9.
  - Result: 2-digit 40 → 39, 10 → 09, 01 → 00.
- **Terminal, `WRAP`=1.** Count 00..0 with `en` → 99..9 on that edge, and `done`=1 for exactly the next cycle.
- **Terminal, `WRAP`=0.** Count 00..0 with `en` → stays 00..0, and `done`=1 for exactly the next cycle. Further enabled edges at zero pulse `done` again each edge; `done` is not sticky.
- **Hold.** `en`=0 and `load`=0 leaves `count` unchanged and gives `done`=0.
- **Internal invalid digits.** Only reachable via X or an upset. On a decrement such a digit goes to 9; when not decrementing it holds.

## Timing
- All outputs reset to: `count`=0, `done`=0, `zero`=1, `bout`=0.
- Load-to-output latency is 1 clock: `count` reflects `load_val` after the loading edge.
- Decrement latency is 1 clock per step; there is no pipelining and no multi-cycle ripple. All digit borrows resolve within one cycle.
- `done` asserts in the cycle after the terminal edge and lasts exactly 1 cycle, unless the next edge is also terminal.
- `zero` and `bout` are combinational and valid in the same cycle as `count`. `bout` drives the next counter's `en` with no added latency, so a cascade of N counters behaves like one (N×DIGITS)-digit counter.
- **`clr` asserted mid-count.** Asynchronous clear takes effect immediately. On deassertion the first edge obeys `load`/`en` normally. Deassertion must be synchronous to `clk` at the system level.
- **`load` and `en` on the same edge as terminal zero.** Load wins, and `done` is not pulsed.

## Structure
- **Package `bcd_pkg`.**
  - Constants: `BCD_W`=4, `BCD_MAX`=4'd9, `BCD_ZERO`=4'd0.
  - Function `bcd_sanitise` (returns 9 for inputs above 9).
  - Shared with the BCD up counter.
- **Sub-module `bcd_down_digit`.** One 4-bit digit register.
  - Inputs: `clk`, `clr`, `load`, `ld_digit`, `dec`.
  - Outputs: `q`, `is_zero`.
  - `bcd_down_counter` instantiates `DIGITS` copies with a generate loop. It builds each digit's `dec` from `en` AND all lower `is_zero` signals.
- **Top level.** Owns the `WRAP` hold logic (suppresses `dec` at all-zero when `WRAP`=0), the `done` register, and `zero`/`bout`.

## Test plan
- **Reset.** Assert `clr` mid-cycle with `count`=57 → `count`=00 immediately, `zero`=1, `done`=0. Release, hold `en`=0 for 5 edges → `count` stays 00.
- **Load then countdown, `DIGITS`=2, `WRAP`=1.** Load 12, then `en`=1 for 14 edges → sequence 12, 11, 10, 09, …, 01, 00, 99, 98. `done`=1 only in the cycle holding 99.
- **Invalid load.** `load_val`=8'hA3 → `count`=93. `load_val`=8'hFF → 99.
- **One-shot, `WRAP`=0.** Load 03, `en`=1 for 6 edges → 02, 01, 00, 00, 00, 00. `done` pulses on each of the three edges taken at 00. `bout`=1 whenever `count`=00 and `en`=1.
- **Priority.** At `count`=00 with `en`=1, assert `load`=1 with `load_val`=45 on the same edge → `count`=45, `done`=0.
- **Cascade.** Two `DIGITS`=1 instances, with the low instance's `bout` driving the high instance's `en`. Load 20 and enable → 19, 18, …, 00, 99, matching a single `DIGITS`=2 instance cycle-for-cycle.
